// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a five-stage pipeline: operand forwarding, load-use and
// branch-compare stalls, data-memory wait stalls, a wait-timeout monitor and
// a saturating count of Decode stall cycles.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  writereg_E,
    input  logic [4:0]  writereg_M,
    input  logic [4:0]  writereg_W,
    input  logic        regwrite_E,
    input  logic        regwrite_M,
    input  logic        regwrite_W,
    input  logic        memtoreg_E,
    input  logic        memtoreg_M,
    input  logic        branch_D,
    input  logic        dmem_req_M,
    input  logic        dmem_ready,
    output logic        forwardA_D,
    output logic        forwardB_D,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_E,
    output logic        flush_W,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    // Memory-wait FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Grouped hazard conditions, kept together for readability in waves
    typedef struct packed {
        logic lwstall;
        logic branchstall;
        logic memstall;
    } hazard_t;

    hazard_t     hz;
    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;
    logic        hazard_stall;

    // Execute operand select: Memory ALU result beats Writeback result,
    // and register 0 never forwards.
    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0 && rw_m && src == wr_m)
            sel = 2'b10;
        else if (src != 5'd0 && rw_w && src == wr_w)
            sel = 2'b01;
        return sel;
    endfunction

    // Forwarding selects for the Execute ALU and the Decode comparator
    always_comb begin
        forwardA_E = fwd_sel_e(rs_E, regwrite_M, writereg_M, regwrite_W, writereg_W);
        forwardB_E = fwd_sel_e(rt_E, regwrite_M, writereg_M, regwrite_W, writereg_W);
        forwardA_D = (rs_D != 5'd0) && regwrite_M && (rs_D == writereg_M);
        forwardB_D = (rt_D != 5'd0) && regwrite_M && (rt_D == writereg_M);
    end

    // Hazard detection; a load into r0 produces no real dependency
    always_comb begin
        hz.lwstall     = memtoreg_E && (rt_E != 5'd0) &&
                         ((rs_D == rt_E) || (rt_D == rt_E));
        hz.branchstall = branch_D &&
                         ((regwrite_E && (writereg_E != 5'd0) &&
                           ((writereg_E == rs_D) || (writereg_E == rt_D))) ||
                          (memtoreg_M && (writereg_M != 5'd0) &&
                           ((writereg_M == rs_D) || (writereg_M == rt_D))));
        hz.memstall    = dmem_req_M && !dmem_ready;
    end

    // Stall/flush fan-out; a memory wait freezes Execute so it must not be
    // flushed, and the Decode hazard is re-judged once memory completes.
    always_comb begin
        hazard_stall = hz.lwstall || hz.branchstall;
        stall_F      = hazard_stall || hz.memstall;
        stall_D      = hazard_stall || hz.memstall;
        stall_E      = hz.memstall;
        stall_M      = hz.memstall;
        flush_W      = hz.memstall;
        flush_E      = hazard_stall && !hz.memstall;
    end

    // Next state of the memory-wait FSM
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hz.memstall) state_next = WAIT;
            WAIT:    if (dmem_ready || !dmem_req_M) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // FSM state, saturating wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT && state_next == WAIT) begin
                wait_cnt <= wait_inc;
                if (wait_inc == TIMEOUT_CNT)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    // Saturating count of cycles spent with Decode stalled
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= 16'd0;
        else if (stall_D && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. The driver applies vectors just
// after each rising edge and queues hand-computed expectations; a monitor
// on the falling edge pops and compares them. Negative expectation = skip.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E;
    logic [4:0]  writereg_E, writereg_M, writereg_W;
    logic        regwrite_E, regwrite_M, regwrite_W;
    logic        memtoreg_E, memtoreg_M, branch_D;
    logic        dmem_req_M, dmem_ready;
    logic        forwardA_D, forwardB_D;
    logic [1:0]  forwardA_E, forwardB_E;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_E, flush_W, mem_timeout;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int fa, fb, fad, fbd, stl, stlm, fle, tmo, sc, st, cnt;
    } exp_t;

    exp_t q[$];

    pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M), .branch_D(branch_D),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_E(flush_E), .flush_W(flush_W),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, exp);
        end
    endtask

    // Monitor: outputs are settled mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "forwardA_E", int'(forwardA_E), e.fa);
            chk(e.name, "forwardB_E", int'(forwardB_E), e.fb);
            chk(e.name, "forwardA_D", int'(forwardA_D), e.fad);
            chk(e.name, "forwardB_D", int'(forwardB_D), e.fbd);
            chk(e.name, "stall_F",    int'(stall_F),    e.stl);
            chk(e.name, "stall_D",    int'(stall_D),    e.stl);
            chk(e.name, "stall_E",    int'(stall_E),    e.stlm);
            chk(e.name, "stall_M",    int'(stall_M),    e.stlm);
            chk(e.name, "flush_W",    int'(flush_W),    e.stlm);
            chk(e.name, "flush_E",    int'(flush_E),    e.fle);
            chk(e.name, "mem_timeout", int'(mem_timeout), e.tmo);
            chk(e.name, "stall_cycles", int'(stall_cycles), e.sc);
            chk(e.name, "state",      int'(dut.state),    e.st);
            chk(e.name, "wait_cnt",   int'(dut.wait_cnt), e.cnt);
        end
    end

    task automatic push(input string n, input int fa, input int fb, input int fad,
                        input int fbd, input int stl, input int stlm, input int fle,
                        input int tmo = -1, input int sc = -1, input int st = -1,
                        input int cnt = -1);
        exp_t e;
        e.name = n; e.fa = fa; e.fb = fb; e.fad = fad; e.fbd = fbd;
        e.stl = stl; e.stlm = stlm; e.fle = fle;
        e.tmo = tmo; e.sc = sc; e.st = st; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
        writereg_E = 0; writereg_M = 0; writereg_W = 0;
        regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
        memtoreg_E = 0; memtoreg_M = 0; branch_D = 0;
        dmem_req_M = 0; dmem_ready = 0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        cyc();
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0;

        // Forwarding priority and r0 exclusion
        regwrite_M = 1; writereg_M = 5; regwrite_W = 1; writereg_W = 5; rs_E = 5;
        push("fwd_mem", 2, 0, 0, 0, 0, 0, 0);
        cyc();
        writereg_M = 6; rt_E = 6;
        push("fwd_wb", 1, 2, 0, 0, 0, 0, 0);
        cyc();
        rs_E = 0; writereg_M = 5; rt_E = 5;
        push("fwd_r0", 0, 2, 0, 0, 0, 0, 0);
        cyc();
        rs_D = 5; rt_D = 5; rs_E = 7; rt_E = 7;
        push("fwd_dec", 0, 0, 1, 1, 0, 0, 0, -1, 0);
        cyc();
        writereg_M = 0; writereg_W = 0; rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
        push("fwd_wr0", 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Load-use stall
        clr();
        memtoreg_E = 1; rt_E = 3; rs_D = 3;
        push("lw_rs", 0, 0, 0, 0, 1, 0, 1, -1, 0);
        cyc();
        clr();
        push("lw_count", 0, 0, 0, 0, 0, 0, 0, -1, 1);
        cyc();
        memtoreg_E = 1; rt_E = 3; rs_D = 7; rt_D = 3;
        push("lw_rt", 0, 0, 0, 0, 1, 0, 1, -1, 1);
        cyc();
        clr();
        memtoreg_E = 1; rt_E = 0; rs_D = 0;
        push("lw_r0", 0, 0, 0, 0, 0, 0, 0, -1, 2);
        cyc();

        // Branch compare stalls
        clr();
        branch_D = 1; rs_D = 4; regwrite_E = 1; writereg_E = 4;
        push("br_exec", 0, 0, 0, 0, 1, 0, 1, -1, 2);
        cyc();
        writereg_E = 0;
        push("br_r0", 0, 0, 0, 0, 0, 0, 0, -1, 3);
        cyc();
        clr();
        branch_D = 1; rt_D = 9; memtoreg_M = 1; regwrite_M = 1; writereg_M = 9;
        push("br_load", 0, 0, 0, 1, 1, 0, 1, -1, 3);
        cyc();

        // Memory wait dominating a load-use stall
        clr();
        memtoreg_E = 1; rt_E = 3; rs_D = 3; dmem_req_M = 1;
        push("mw_1", 0, 0, 0, 0, 1, 1, 0, 0, 4, 0, 0);
        cyc();
        push("mw_2", 0, 0, 0, 0, 1, 1, 0, 0, 5, 1, 0);
        cyc();
        push("mw_3", 0, 0, 0, 0, 1, 1, 0, 0, 6, 1, 1);
        cyc();
        dmem_ready = 1;
        push("mw_ready", 0, 0, 0, 0, 1, 0, 1, 0, 7, 1, 2);
        cyc();
        clr();
        push("mw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0);
        cyc();

        // Timeout after four WAIT cycles, sticky across completion
        dmem_req_M = 1;
        push("to_1", 0, 0, 0, 0, 1, 1, 0, 0, 8, 0, 0);
        cyc();
        push("to_2", 0, 0, 0, 0, 1, 1, 0, 0, -1, 1, 0);
        cyc();
        push("to_3", 0, 0, 0, 0, 1, 1, 0, 0, -1, 1, 1);
        cyc();
        push("to_4", 0, 0, 0, 0, 1, 1, 0, 0, -1, 1, 2);
        cyc();
        push("to_5", 0, 0, 0, 0, 1, 1, 0, 0, -1, 1, 3);
        cyc();
        push("to_6", 0, 0, 0, 0, 1, 1, 0, 1, -1, 1, 4);
        cyc();
        dmem_ready = 1;
        push("to_ready", 0, 0, 0, 0, 0, 0, 0, 1, 14, 1, 5);
        cyc();
        clr();
        push("to_sticky", 0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0);
        cyc();

        // Reset in the middle of WAIT with the memory stall persisting
        dmem_req_M = 1;
        push("rw_enter", 0, 0, 0, 0, 1, 1, 0, 1, 14, 0, 0);
        cyc();
        reset = 1;
        push("rw_inreset", 0, 0, 0, 0, 1, 1, 0, 1, 15, 1, 0);
        cyc();
        reset = 0;
        push("rw_after", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc();
        push("rw_rewait", 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0);
        cyc();

        // Stall counter saturation (and wait counter saturation)
        for (int i = 0; i < 65537; i++) cyc();
        push("sat_hold", 0, 0, 0, 0, 1, 1, 0, 1, 16'hFFFF, 1, 255);
        cyc();
        push("sat_nowrap", 0, 0, 0, 0, 1, 1, 0, 1, 16'hFFFF, 1, 255);
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        clr();
        push("sat_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum consecutive data-memory wait cycles before a timeout is flagged (range 1..255).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports rs_D, rt_D, rs_E, rt_E, input, 5 each: source register numbers in Decode and Execute.
REQ-005 The block SHALL have ports writereg_E, writereg_M, writereg_W, input, 5 each: destination register numbers in Execute, Memory and Writeback.
REQ-006 The block SHALL have ports regwrite_E, regwrite_M, regwrite_W, input, 1 each: stage will write the register file.
REQ-007 The block SHALL have ports memtoreg_E, memtoreg_M, input, 1 each: stage holds a load.
REQ-008 The block SHALL have port branch_D, input, 1: Decode holds a branch.
REQ-009 The block SHALL have ports dmem_req_M, input, 1 (Memory stage accesses data memory) and dmem_ready, input, 1 (data memory completes the access this cycle).
REQ-010 The block SHALL have ports forwardA_D, forwardB_D, output, 1 each: Decode comparator operand taken from the Memory-stage ALU result.
REQ-011 The block SHALL have ports forwardA_E, forwardB_E, output, 2 each: Execute ALU operand select (00 register file, 01 Writeback result, 10 Memory ALU result).
REQ-012 The block SHALL have ports stall_F, stall_D, stall_E, stall_M, output, 1 each: hold the pipeline register feeding each stage.
REQ-013 The block SHALL have ports flush_E, flush_W, output, 1 each: load a bubble (all control zero) into the Execute / Writeback register.
REQ-014 The block SHALL have port mem_timeout, output, 1: sticky memory-wait timeout flag.
REQ-015 The block SHALL have port stall_cycles, output, 16: count of cycles with stall_D asserted.

Function
REQ-016 forwardA_E SHALL be 10 if rs_E!=0, regwrite_M and rs_E==writereg_M; else 01 if rs_E!=0, regwrite_W and rs_E==writereg_W; else 00; forwardB_E identical using rt_E; Memory match has priority.
REQ-017 forwardA_D SHALL be 1 iff rs_D!=0, regwrite_M and rs_D==writereg_M; forwardB_D identical using rt_D.
REQ-018 lwstall SHALL be memtoreg_E and (rs_D==rt_E or rt_D==rt_E).
REQ-019 branchstall SHALL be branch_D and ((regwrite_E and writereg_E!=0 and writereg_E in {rs_D,rt_D}) or (memtoreg_M and writereg_M!=0 and writereg_M in {rs_D,rt_D})).
REQ-020 memstall SHALL be dmem_req_M and not dmem_ready, combinational in the same cycle.
REQ-021 Outputs SHALL be: stall_F = stall_D = lwstall or branchstall or memstall; stall_E = stall_M = flush_W = memstall; flush_E = (lwstall or branchstall) and not memstall.
REQ-022 Memstall SHALL dominate: while memstall, flush_E=0 so the held Execute instruction is not lost; the hazard stall re-evaluates once memory completes.
REQ-023 An FSM SHALL have states IDLE and WAIT; IDLE->WAIT when memstall; WAIT->IDLE when dmem_ready or not dmem_req_M; otherwise holds.
REQ-024 An 8-bit wait counter SHALL clear in IDLE and on WAIT->IDLE, and increment each cycle in WAIT, saturating at 255.
REQ-025 mem_timeout SHALL set on the cycle the wait counter reaches TIMEOUT while in WAIT and SHALL remain 1 until reset; it does not alter stalling.
REQ-026 stall_cycles SHALL increment by 1 at each rising edge where stall_D=1, saturating at 16'hFFFF (no wrap).
REQ-027 Writes to register 0 SHALL never cause forwarding or stalls.

Reset
REQ-028 With reset=1 at a rising edge: FSM->IDLE, wait counter=0, mem_timeout=0, stall_cycles=0; reset dominates all simultaneous events.
REQ-029 Combinational outputs (forward*, stall_*, flush_*) SHALL follow inputs during reset; reset mid-WAIT SHALL return to IDLE next cycle, re-entering WAIT if memstall persists.

Verification
REQ-030 The bench SHALL check: regwrite_M=1, writereg_M=5, regwrite_W=1, writereg_W=5, rs_E=5 -> forwardA_E=10; with writereg_M=6 -> 01; rs_E=0 with both matching -> 00.
REQ-031 The bench SHALL check: memtoreg_E=1, rt_E=3, rs_D=3 -> stall_F=stall_D=flush_E=1, stall_E=0, stall_cycles +1 next cycle.
REQ-032 The bench SHALL check: branch_D=1, rs_D=4, regwrite_E=1, writereg_E=4 -> stall_D=1, flush_E=1; same with writereg_E=0 -> no stall.
REQ-033 The bench SHALL check: dmem_req_M=1, dmem_ready=0 for 3 cycles alongside lwstall -> stall_F/D/E/M=1, flush_W=1, flush_E=0 each cycle, FSM WAIT; dmem_ready=1 -> IDLE next cycle, counter 0.
REQ-034 The bench SHALL check: TIMEOUT=4 and dmem_ready held 0 for 6 cycles -> mem_timeout rises after the 4th WAIT cycle and stays 1 after dmem_ready=1 until reset.
REQ-035 The bench SHALL check: stall_D held 1 for 65537 cycles -> stall_cycles=16'hFFFF; reset pulse -> 0.
